// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Holds the FSM state encoding, the port-owner encoding and the default latency.
// Imported by the arbiter, its interface users and the bench.
package mem_arbiter_pkg;

    localparam int LAT_DEFAULT = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and main-memory port of the arbiter.
// Latency: none, wires only.
// Backpressure: req is held by the requester until the matching one-cycle ack.
interface mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_data;

    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;

    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_ack, i_data, d_ack, d_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    // CPU ports plus main memory, i.e. everything around the arbiter.
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_data, d_ack, d_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one main memory between instruction fetch and data ports, data first.
// Latency: request seen in IDLE at cycle n -> ack pulse at cycle n+LAT+1.
// Backpressure: requests are sampled only in IDLE; a busy arbiter simply leaves req pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    // Counter reload: LAT-1 down to 0 gives exactly LAT ACCESS cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    owner_t           owner_q;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic             wr_q;
    logic [15:0]      i_data_q;
    logic [15:0]      d_rdata_q;
    logic             grant_d;
    logic             grant_i;
    logic             last_access;

    assign last_access = (state_q == ACCESS) && (cnt_q == '0);

    // Next-state and grant decode; data port wins when both request in IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    grant_d = 1'b1;
                    state_d = ACCESS;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the granted request so memory signals stay stable even if req drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_I;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_d) begin
            owner_q <= OWN_D;
            addr_q  <= bus.d_addr & 16'hFFFE;
            wr_q    <= bus.d_wr;
            wdata_q <= bus.d_wdata;
        end else if (grant_i) begin
            owner_q <= OWN_I;
            addr_q  <= bus.i_addr & 16'hFFFE;
            wr_q    <= 1'b0;
        end
    end

    // Access-length counter: loaded on grant, counts down through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (grant_d || grant_i) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Capture read data in the last access cycle; writes leave d_rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else if (last_access) begin
            if (owner_q == OWN_I) begin
                i_data_q <= bus.mem_rdata;
            end else if (!wr_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // All outputs decode from registers, so they are glitch-free and constant per state.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_wr    = (state_q == ACCESS) && (owner_q == OWN_D) && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_ack     = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    assign bus.i_data    = i_data_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scoreboard of expected acks, memory model on the mem port.
// Latency: expects ack LAT+1 cycles after the IDLE cycle a request is seen.
// Backpressure: requests are held until ack, then dropped or re-used as a new request.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LAT = LAT_DEFAULT;

    typedef struct {
        bit          is_d;
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] d_rdata_exp = '0;
    logic [15:0] i_data_exp  = '0;

    mem_arbiter_if bus();

    mem_arbiter #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory model: combinational read, write on each enabled write cycle.
    assign bus.mem_rdata = mem[bus.mem_addr[8:1]];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[8:1]] <= bus.mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with per-cycle checks of the memory port and the ack.
    task automatic xact(input string name, input bit is_d, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wdata, input int drop_k);
        exp_t        e;
        int          c0;
        int          got_c;
        bit          seen;
        logic [15:0] a_al;
        logic [15:0] got_data;
        a_al = addr & 16'hFFFE;
        tick();
        c0 = cyc;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        e.is_d = is_d;
        e.cyc  = c0 + LAT + 1;
        e.data = (is_d && wr) ? d_rdata_exp : ref_mem[a_al[8:1]];
        sb.push_back(e);
        if (is_d && wr) ref_mem[a_al[8:1]] = wdata;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == drop_k) begin bus.d_req = 1'b0; bus.i_req = 1'b0; end
            @(negedge clk);
            checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_addr !== a_al || bus.mem_wr !== (is_d & wr)
                || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
                errors++;
                $display("FAIL %s access cyc%0d: en=%b addr=%h wr=%b ack=%b%b, want en=1 addr=%h wr=%b ack=00",
                         name, k, bus.mem_en, bus.mem_addr, bus.mem_wr, bus.i_ack, bus.d_ack, a_al, is_d & wr);
            end
            if (is_d && wr) begin
                checks++;
                if (bus.mem_wdata !== wdata) begin
                    errors++;
                    $display("FAIL %s wdata cyc%0d: got %h want %h", name, k, bus.mem_wdata, wdata);
                end
            end
        end
        seen = 1'b0;
        got_c = 0;
        for (int n = 0; n < LAT + 4 && !seen; n++) begin
            tick();
            if (n == 0) begin bus.d_req = 1'b0; bus.i_req = 1'b0; end
            @(negedge clk);
            if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
                seen = 1'b1;
                got_c = cyc;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s ack timeout: no ack, want ack at cycle %0d", name, e.cyc);
        end else begin
            got_data = e.is_d ? bus.d_rdata : bus.i_data;
            if (bus.d_ack !== e.is_d || bus.i_ack !== !e.is_d || got_c != e.cyc
                || got_data !== e.data || bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL %s ack: i/d_ack=%b%b cyc=%0d data=%h en=%b wr=%b, want %b%b cyc=%0d data=%h en=0 wr=0",
                         name, bus.i_ack, bus.d_ack, got_c, got_data, bus.mem_en, bus.mem_wr,
                         !e.is_d, e.is_d, e.cyc, e.data);
            end
        end
        if (e.is_d) d_rdata_exp = e.data;
        else        i_data_exp  = e.data;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_wr} !== 4'b0000
            || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset ctrl: ack=%b%b en=%b wr=%b addr=%h wdata=%h, want all 0",
                     bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.i_data !== 16'h0 || bus.d_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset data: i_data=%h d_rdata=%h, want 0 0", bus.i_data, bus.d_rdata);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL idle mem_en cyc%0d: got %b want 0", k, bus.mem_en);
            end
        end
    endtask

    task automatic test_fetch;
        xact("fetch", 1'b0, 1'b0, 16'h0010, 16'h0, 0);
    endtask

    task automatic test_write;
        xact("dread", 1'b1, 1'b0, 16'h0040, 16'h0, 0);
        xact("write", 1'b1, 1'b1, 16'h0023, 16'hBEEF, 0);
        xact("rdback", 1'b1, 1'b0, 16'h0022, 16'h0, 0);
    endtask

    task automatic test_drop;
        xact("drop", 1'b1, 1'b0, 16'h0044, 16'h0, 2);
    endtask

    // Both ports request together: data first, fetch granted in the IDLE cycle after RESP.
    task automatic test_contention;
        exp_t e;
        int   c0;
        logic [15:0] got_data;
        tick();
        c0 = cyc;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0046;
        bus.i_req = 1'b1; bus.i_addr = 16'h0030;
        e.is_d = 1'b1; e.cyc = c0 + LAT + 1;     e.data = ref_mem[8'h23]; sb.push_back(e);
        e.is_d = 1'b0; e.cyc = c0 + 2*LAT + 3;   e.data = ref_mem[8'h18]; sb.push_back(e);
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            tick();
            @(negedge clk);
            if (cyc == c0 + LAT + 3) begin
                checks++;
                if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0030) begin
                    errors++;
                    $display("FAIL contention fetch grant: en=%b addr=%h want en=1 addr=0030",
                             bus.mem_en, bus.mem_addr);
                end
            end
            if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL contention dual ack: i_ack=1 d_ack=1 want at most one");
            end
            if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
                e = sb.pop_front();
                got_data = e.is_d ? bus.d_rdata : bus.i_data;
                checks++;
                if (bus.d_ack !== e.is_d || cyc != e.cyc || got_data !== e.data) begin
                    errors++;
                    $display("FAIL contention ack: d_ack=%b cyc=%0d data=%h, want d_ack=%b cyc=%0d data=%h",
                             bus.d_ack, cyc, got_data, e.is_d, e.cyc, e.data);
                end
                if (e.is_d) begin bus.d_req = 1'b0; d_rdata_exp = e.data; end
                else        begin bus.i_req = 1'b0; i_data_exp  = e.data; end
            end
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL contention timeout: %0d acks missing, want 0", sb.size());
            sb.delete();
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
    endtask

    // A fetch request held high across its ack is served again as a new request.
    task automatic test_back_to_back;
        exp_t e;
        int   c0;
        tick();
        c0 = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        e.is_d = 1'b0; e.cyc = c0 + LAT + 1; e.data = ref_mem[8'h08]; sb.push_back(e);
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            tick();
            @(negedge clk);
            if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (bus.i_ack !== 1'b1 || cyc != e.cyc || bus.i_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b ack: i_ack=%b cyc=%0d data=%h, want i_ack=1 cyc=%0d data=%h",
                             bus.i_ack, cyc, bus.i_data, e.cyc, e.data);
                end
                i_data_exp = e.data;
                if (e.cyc == c0 + LAT + 1) begin
                    bus.i_addr = 16'h0012;
                    e.cyc = c0 + 2*LAT + 3; e.data = ref_mem[8'h09]; sb.push_back(e);
                end else begin
                    bus.i_req = 1'b0;
                end
            end
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL b2b timeout: %0d acks missing, want 0", sb.size());
            sb.delete();
        end
        bus.i_req = 1'b0;
    endtask

    // Reset in the middle of ACCESS: no ack, everything cleared, next request served normally.
    task automatic test_abort;
        bit acked;
        tick();
        bus.i_req = 1'b1; bus.i_addr = 16'h0050;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_wr} !== 4'b0000
            || bus.mem_addr !== 16'h0 || bus.i_data !== 16'h0 || bus.d_rdata !== 16'h0) begin
            errors++;
            $display("FAIL abort reset: ack=%b%b en=%b wr=%b addr=%h i_data=%h d_rdata=%h, want all 0",
                     bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.i_data, bus.d_rdata);
        end
        i_data_exp = '0;
        d_rdata_exp = '0;
        bus.i_req = 1'b0;
        tick();
        rst_n = 1'b1;
        acked = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1 || bus.mem_en === 1'b1) acked = 1'b1;
        end
        checks++;
        if (acked) begin
            errors++;
            $display("FAIL abort no-ack: activity seen after aborted fetch, want none");
        end
        xact("after_abort", 1'b0, 1'b0, 16'h0060, 16'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h3C00 ^ 16'(i * 16'h0107);
            ref_mem[i] = 16'h3C00 ^ 16'(i * 16'h0107);
        end
        mem[8]     = 16'hA123;
        ref_mem[8] = 16'hA123;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        test_reset();
        test_fetch();
        test_write();
        test_drop();
        test_contention();
        test_back_to_back();
        test_abort();

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 4, meaning main-memory access latency in cycles (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 The block SHALL have port i_addr  input  16  instruction-fetch byte address.
REQ-006 The block SHALL have port i_ack  output  1  one-cycle pulse: fetch complete, i_data valid.
REQ-007 The block SHALL have port i_data  output  16  registered fetched instruction.
REQ-008 The block SHALL have port d_req  input  1  data request, held until d_ack.
REQ-009 The block SHALL have port d_wr  input  1  data request is a write (1) or read (0).
REQ-010 The block SHALL have port d_addr  input  16  data byte address.
REQ-011 The block SHALL have port d_wdata  input  16  data to write.
REQ-012 The block SHALL have port d_ack  output  1  one-cycle pulse: data access complete.
REQ-013 The block SHALL have port d_rdata  output  16  registered read data.
REQ-014 The block SHALL have port mem_en  output  1  main-memory enable.
REQ-015 The block SHALL have port mem_wr  output  1  main-memory write strobe.
REQ-016 The block SHALL have port mem_addr  output  16  main-memory address, bit 0 forced to 0.
REQ-017 The block SHALL have port mem_wdata  output  16  main-memory write data.
REQ-018 The block SHALL have port mem_rdata  input  16  main-memory read data, valid in the last access cycle.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-020 In IDLE with d_req=1, the block SHALL grant the data port; in IDLE with only i_req=1, it SHALL grant the instruction port (data has fixed priority).
REQ-021 On a grant, the block SHALL latch the address, d_wr and d_wdata, record the owner, load the counter with LAT-1 and enter ACCESS on the next edge.
REQ-022 In ACCESS, the block SHALL drive mem_en=1, mem_addr, mem_wdata and mem_wr=(owner is data AND latched d_wr) from registers, constant for exactly LAT cycles.
REQ-023 In ACCESS, the block SHALL decrement the counter each cycle; at count 0 it SHALL capture mem_rdata into i_data or d_rdata (reads only) and enter RESP.
REQ-024 In RESP, the block SHALL assert exactly one ack (i_ack or d_ack), drive mem_en=0, and return to IDLE.
REQ-025 Latency SHALL be: request seen in IDLE at cycle n -> ack at cycle n+LAT+1.
REQ-026 On a data write, d_rdata SHALL hold its previous value.
REQ-027 The earliest next grant SHALL occur in the IDLE cycle after RESP; both ports may therefore be served alternately under contention.
REQ-028 If a requester drops its req during ACCESS, the access SHALL still complete and ack SHALL still pulse.
REQ-029 Request inputs SHALL be ignored outside IDLE; a req still high in the IDLE cycle following its own ack SHALL be treated as a new request.
REQ-030 i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-031 When mem_en=0, mem_wr SHALL be 0.

Reset
REQ-032 While rst_n=0, the block SHALL force state=IDLE, counter=0, i_ack=d_ack=0, mem_en=mem_wr=0, mem_addr=mem_wdata=0 and i_data=d_rdata=0.
REQ-033 Reset asserted mid-ACCESS SHALL abort the access with no ack; after release, the block SHALL arbitrate afresh from IDLE.

Structure
REQ-034 The shared CPU package SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), the owner encoding (OWN_I, OWN_D) and the LAT default.
REQ-035 The block SHALL be one module with no sub-module; the 4-bit latency counter SHALL stay inline.

Verification
REQ-036 Reset: with rst_n=0, all outputs SHALL be 0; after release with no req, mem_en SHALL stay 0.
REQ-037 Single fetch: i_req=1, i_addr=16'h0010 at cycle 0, mem_rdata=16'hA123 -> mem_en=1 for cycles 1-4 with mem_addr=16'h0010, then i_ack=1 and i_data=16'hA123 at cycle 5.
REQ-038 Contention: i_req and d_req rise together (d_wr=0, d_addr=16'h0040) -> data is served first with d_ack at cycle 5, then the fetch is granted at cycle 6 with i_ack at cycle 11.
REQ-039 Write: d_wr=1, d_addr=16'h0023, d_wdata=16'hBEEF -> mem_addr=16'h0022, mem_wr=1 and mem_wdata=16'hBEEF for 4 cycles, then d_ack=1 with d_rdata unchanged.
REQ-040 Abort: rst_n pulsed low at cycle 2 of a fetch -> no i_ack; a new request after release completes in LAT+1 cycles.
REQ-041 Dropped request: d_req deasserted in cycle 2 of ACCESS -> d_ack SHALL still pulse at cycle 5.
